// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared RTC types: NMEA parser state encoding and BCD field limits
// Contents: nmea_state_t parser states; BCD_UNITS_MAX, BCD_TENS_MAX, BCD_HOURS_MAX.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_TIME,
    ST_FRAC,
    ST_STATUS,
    ST_STATCOMMA,
    ST_ARMED
  } nmea_state_t;

  localparam logic [3:0] BCD_UNITS_MAX = 4'h9;
  localparam logic [3:0] BCD_TENS_MAX  = 4'h5;
  localparam logic [5:0] BCD_HOURS_MAX = 6'h23;

endpackage

// File: rtl/bcd_time_incr.sv
// rtl/bcd_time_incr.sv - combinational BCD hh:mm:ss plus one second
// Ports: i_time [21:0] BCD {hh, mm, ss} in; o_time [21:0] same time plus one second,
//        23:59:59 wraps to 00:00:00.
module bcd_time_incr (
  input  logic [21:0] i_time,
  output logic [21:0] o_time
);
  import rtc_pkg::*;

  // Each digit increments only when every lower digit is at its maximum.
  always_comb begin
    o_time = i_time;
    if (i_time[3:0] != BCD_UNITS_MAX) begin
      o_time[3:0] = i_time[3:0] + 4'd1;
    end else begin
      o_time[3:0] = 4'd0;
      if (i_time[7:4] != BCD_TENS_MAX) begin
        o_time[7:4] = i_time[7:4] + 4'd1;
      end else begin
        o_time[7:4] = 4'd0;
        if (i_time[11:8] != BCD_UNITS_MAX) begin
          o_time[11:8] = i_time[11:8] + 4'd1;
        end else begin
          o_time[11:8] = 4'd0;
          if (i_time[15:12] != BCD_TENS_MAX) begin
            o_time[15:12] = i_time[15:12] + 4'd1;
          end else begin
            o_time[15:12] = 4'd0;
            if (i_time[21:16] == BCD_HOURS_MAX) begin
              o_time[21:16] = 6'd0;
            end else if (i_time[19:16] == BCD_UNITS_MAX) begin
              o_time[19:16] = 4'd0;
              o_time[21:20] = i_time[21:20] + 2'd1;
            end else begin
              o_time[19:16] = i_time[19:16] + 4'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/nmea_time_setter.sv
// rtl/nmea_time_setter.sv - parse $G[PN]RMC time and write it to the RTC on the next PPS
// Ports: i_clk, i_reset (sync, active high); i_stb/i_byte serial byte in; i_pps second strobe;
//        o_wr write strobe, o_data BCD {hh,mm,ss}, o_valid field mask, o_armed time pending.
module nmea_time_setter #(
  parameter logic OPT_ADD_SECOND = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stb,
  input  logic [7:0]  i_byte,
  input  logic        i_pps,
  output logic        o_wr,
  output logic [21:0] o_data,
  output logic [2:0]  o_valid,
  output logic        o_armed
);
  import rtc_pkg::*;

  nmea_state_t state, state_d;
  logic [2:0]  cnt, cnt_d;
  logic [23:0] cap, cap_d;
  logic [21:0] stored;
  logic [21:0] last_data;
  logic [21:0] cap_plus1;
  logic        load;
  logic        range_ok;
  logic        is_digit;
  logic        is_dollar;

  bcd_time_incr u_incr (
    .i_time (cap[21:0]),
    .o_time (cap_plus1)
  );

  function automatic logic hdr_char_ok(input logic [2:0] idx, input logic [7:0] b);
    case (idx)
      3'd0:    hdr_char_ok = (b == "G");
      3'd1:    hdr_char_ok = (b == "P") || (b == "N");
      3'd2:    hdr_char_ok = (b == "R");
      3'd3:    hdr_char_ok = (b == "M");
      3'd4:    hdr_char_ok = (b == "C");
      3'd5:    hdr_char_ok = (b == ",");
      default: hdr_char_ok = 1'b0;
    endcase
  endfunction

  assign is_digit  = (i_byte >= "0") && (i_byte <= "9");
  assign is_dollar = i_stb && (i_byte == "$");

  // The hours tens digit is captured as a full nibble so an out-of-range
  // value in its upper bits is still rejected.
  assign range_ok = (cap[23:22] == 2'd0) && (cap[21:16] <= BCD_HOURS_MAX) &&
                    (cap[15:12] <= BCD_TENS_MAX) && (cap[7:4] <= BCD_TENS_MAX);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      cap       <= 24'd0;
      stored    <= 22'd0;
      last_data <= 22'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      cap   <= cap_d;
      if (load)
        stored <= OPT_ADD_SECOND ? cap_plus1 : cap[21:0];
      if (o_wr)
        last_data <= stored;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cap_d   = cap;
    load    = 1'b0;
    o_wr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_dollar) begin
          state_d = ST_HDR;
          cnt_d   = 3'd0;
        end
      end
      ST_ARMED: begin
        // The write lands in the PPS cycle itself so it replaces that
        // second's increment; a byte arriving with it is handled as IDLE.
        if (i_pps && !i_reset) begin
          o_wr    = 1'b1;
          state_d = ST_IDLE;
        end
        if (is_dollar) begin
          state_d = ST_HDR;
          cnt_d   = 3'd0;
        end
      end
      default: begin
        if (is_dollar) begin
          state_d = ST_HDR;
          cnt_d   = 3'd0;
          cap_d   = 24'd0;
        end else if (i_stb) begin
          state_d = ST_IDLE;
          case (state)
            ST_HDR: begin
              if (hdr_char_ok(cnt, i_byte)) begin
                state_d = (cnt == 3'd5) ? ST_TIME : ST_HDR;
                cnt_d   = (cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
                cap_d   = 24'd0;
              end
            end
            ST_TIME: begin
              if (cnt != 3'd6) begin
                if (is_digit) begin
                  state_d = ST_TIME;
                  cap_d   = {cap[19:0], i_byte[3:0]};
                  cnt_d   = cnt + 3'd1;
                end
              end else if (i_byte == ".") begin
                state_d = ST_FRAC;
              end else if (i_byte == ",") begin
                state_d = ST_STATUS;
              end
            end
            ST_FRAC: begin
              if (is_digit)
                state_d = ST_FRAC;
              else if (i_byte == ",")
                state_d = ST_STATUS;
            end
            ST_STATUS: begin
              if (i_byte == "A")
                state_d = ST_STATCOMMA;
            end
            ST_STATCOMMA: begin
              if ((i_byte == ",") && range_ok) begin
                state_d = ST_ARMED;
                load    = 1'b1;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  assign o_data  = o_wr ? stored : last_data;
  assign o_valid = o_wr ? 3'b111 : 3'b000;
  assign o_armed = (state == ST_ARMED);

endmodule

// File: tb/tb_nmea_time_setter.sv
// tb/tb_nmea_time_setter.sv - scoreboard bench for nmea_time_setter with and without the +1 s option
module tb_nmea_time_setter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic [7:0]  bt  = 8'h00;
  logic        pps = 1'b0;

  logic        wr_a, wr_b, armed_a, armed_b;
  logic [21:0] data_a, data_b;
  logic [2:0]  valid_a, valid_b;

  int total = 0;
  int bad   = 0;
  int nwr_a = 0;
  int nwr_b = 0;

  logic [21:0] q_a[$];
  logic [21:0] q_b[$];
  logic [21:0] last_a = 22'd0;
  logic [21:0] last_b = 22'd0;

  always #5 clk = ~clk;

  nmea_time_setter #(.OPT_ADD_SECOND(1'b1)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_byte(bt), .i_pps(pps),
    .o_wr(wr_a), .o_data(data_a), .o_valid(valid_a), .o_armed(armed_a)
  );

  nmea_time_setter #(.OPT_ADD_SECOND(1'b0)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_byte(bt), .i_pps(pps),
    .o_wr(wr_b), .o_data(data_b), .o_valid(valid_b), .o_armed(armed_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic [7:0] b, input logic p);
    @(posedge clk);
    #1;
    stb = s;
    bt  = b;
    pps = p;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++)
      step(1'b1, s[i], 1'b0);
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic expect_wr(input logic [21:0] ea, input logic [21:0] eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  task automatic fire_pps();
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic monitor();
    logic [21:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("wr_a_in_reset", {31'd0, wr_a}, 32'd0);
        chk("wr_b_in_reset", {31'd0, wr_b}, 32'd0);
        last_a = 22'd0;
        last_b = 22'd0;
      end else begin
        if (wr_a) begin
          nwr_a++;
          if (q_a.size() == 0) begin
            chk("unexpected_wr_a", {31'd0, wr_a}, 32'd0);
          end else begin
            e = q_a.pop_front();
            chk("data_a", {10'd0, data_a}, {10'd0, e});
            chk("valid_a", {29'd0, valid_a}, 32'd7);
            last_a = e;
          end
        end else begin
          chk("idle_valid_a", {29'd0, valid_a}, 32'd0);
          chk("hold_data_a", {10'd0, data_a}, {10'd0, last_a});
        end
        if (wr_b) begin
          nwr_b++;
          if (q_b.size() == 0) begin
            chk("unexpected_wr_b", {31'd0, wr_b}, 32'd0);
          end else begin
            e = q_b.pop_front();
            chk("data_b", {10'd0, data_b}, {10'd0, e});
            chk("valid_b", {29'd0, valid_b}, 32'd7);
            last_b = e;
          end
        end else begin
          chk("idle_valid_b", {29'd0, valid_b}, 32'd0);
          chk("hold_data_b", {10'd0, data_b}, {10'd0, last_b});
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    chk("reset_armed", {31'd0, armed_a}, 32'd0);
    chk("reset_data", {10'd0, data_a}, 32'd0);
    chk("reset_valid", {29'd0, valid_a}, 32'd0);
    chk("reset_wr", {31'd0, wr_a}, 32'd0);

    // Fractional seconds, simple +1
    send("$GPRMC,123456.00,A,");
    chk("armed_frac_a", {31'd0, armed_a}, 32'd1);
    chk("armed_frac_b", {31'd0, armed_b}, 32'd1);
    expect_wr(22'h12_34_57, 22'h12_34_56);
    fire_pps();
    chk("disarmed_after_wr", {31'd0, armed_a}, 32'd0);

    // Midnight wrap
    send("$GNRMC,235959,A,");
    chk("armed_wrap", {31'd0, armed_a}, 32'd1);
    expect_wr(22'h00_00_00, 22'h23_59_59);
    fire_pps();

    // Hours-unit carry
    send("$GPRMC,095959,A,");
    expect_wr(22'h10_00_00, 22'h09_59_59);
    fire_pps();

    // Void fix
    send("$GPRMC,123456,V,");
    chk("void_armed", {31'd0, armed_a}, 32'd0);
    fire_pps();

    // Hours out of range
    send("$GPRMC,246000,A,");
    chk("range_armed", {31'd0, armed_a}, 32'd0);
    fire_pps();

    // Minutes tens out of range
    send("$GPRMC,126000,A,");
    chk("min_range_armed", {31'd0, armed_b}, 32'd0);
    fire_pps();

    // Wrong sentence type
    send("$GPGGA,123456,A,");
    chk("gga_armed", {31'd0, armed_a}, 32'd0);
    fire_pps();

    // '$' while armed discards the pending time
    send("$GPRMC,010101,A,");
    chk("armed_before_dollar", {31'd0, armed_a}, 32'd1);
    send("$");
    chk("dollar_disarms", {31'd0, armed_a}, 32'd0);
    fire_pps();

    // Reset while armed, with PPS on the reset cycle and the cycle after
    send("$GPRMC,020202,A,");
    chk("armed_before_reset", {31'd0, armed_b}, 32'd1);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("reset_disarms", {31'd0, armed_a}, 32'd0);
    fire_pps();

    // PPS and '$' together: write issued, then the new sentence arms
    send("$GPRMC,115959,A,");
    expect_wr(22'h12_00_00, 22'h11_59_59);
    step(1'b1, "$", 1'b1);
    send("GPRMC,010203,A,");
    chk("rearm_after_pps_dollar", {31'd0, armed_a}, 32'd1);
    expect_wr(22'h01_02_04, 22'h01_02_03);
    fire_pps();
    step(1'b0, 8'h00, 1'b0);

    chk("writes_a", nwr_a, 32'd5);
    chk("writes_b", nwr_b, 32'd5);
    chk("queue_a_empty", q_a.size(), 32'd0);
    chk("queue_b_empty", q_b.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
